// File: rtl/edge_morph_pkg.sv
// Shared constants and types for the binary morphology stages of the video pipeline.
package edge_morph_pkg;

    localparam logic [7:0] EDGE_LEVEL    = 8'h00;
    localparam logic [7:0] BG_LEVEL      = 8'hFF;
    localparam int         MORPH_LATENCY = 3;

    // Row position within the frame, saturating once two previous lines are available.
    typedef enum logic [1:0] {
        ROW_0  = 2'd0,
        ROW_1  = 2'd1,
        ROW_2P = 2'd2
    } row_state_t;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

    function automatic logic [7:0] morph_level(input logic de, input logic hit);
        if (!de) begin
            return 8'h00;
        end
        return hit ? EDGE_LEVEL : BG_LEVEL;
    endfunction

endpackage

// File: rtl/edge_dilate_3x3_if.sv
// Pixel stream bundle (syncs + 8-bit data) used on both sides of the dilation stage.
interface edge_dilate_3x3_if;

    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] data;

    modport master (output vs, hs, de, data);
    modport slave  (input  vs, hs, de, data);

endinterface

// File: rtl/edge_line_buf.sv
// 1-bit simple dual-port line memory, registered read; a read and write to the same
// address in one cycle returns the old contents.
module edge_line_buf #(
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_data_o
);

    logic mem_q [DEPTH];
    logic rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/edge_dilate_3x3.sv
// 3x3 binary dilation of the thresholded Sobel stream, 3-cycle latency on data and syncs.
// Optional per-frame edge statistics are built when EDGE_STATS_EN is defined.
//
//   state  | meaning
//   ROW_0  | first line of frame (or after reset): no previous lines valid
//   ROW_1  | second line: line buffer 0 valid, buffer 1 not yet
//   ROW_2P | third line onwards: both line buffers valid
module edge_dilate_3x3
    import edge_morph_pkg::*;
#(
    parameter int IMG_WIDTH = 1280,
    parameter int CNT_W     = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    edge_dilate_3x3_if.slave   sobel,
    edge_dilate_3x3_if.master  morph
`ifdef EDGE_STATS_EN
    ,
    output logic [CNT_W-1:0]   edge_count
`endif
);

    localparam int              AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [AW-1:0]   COL_LAST = AW'(IMG_WIDTH - 1);
    localparam int              SL       = MORPH_LATENCY - 1;

    logic                 pix_e;
    logic [AW-1:0]        col_q, col_d;
    logic                 col_full_q, col_full_d;
    logic                 lb0_wr_en;
    logic                 de_prev_q;
    row_state_t           row_q, row_d;
    row_state_t           row_eff;

    logic                 s1_e_q;
    row_state_t           s1_row_q;
    logic                 s1_wr_en_q;
    logic [AW-1:0]        s1_addr_q;
    logic                 lb0_rd, lb1_rd;
    logic [2:0]           col_taps;
    logic [8:0]           win_q, win_d;
    logic                 win_hit;
    sync_t [SL:0]         sync_q;
    logic [7:0]           data_q;

    assign pix_e = sobel.de & ~sobel.data[7];

    // Column counter; pixels beyond the last column are processed but never stored.
    always_comb begin
        col_d      = col_q;
        col_full_d = col_full_q;
        if (!sobel.de) begin
            col_d      = '0;
            col_full_d = 1'b0;
        end else if (col_q == COL_LAST) begin
            col_full_d = 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    assign lb0_wr_en = sobel.de & ~col_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= ROW_0;
        end else begin
            row_q <= row_d;
        end
    end

    always_comb begin
        row_d = row_q;
        if (sobel.vs) begin
            row_d = ROW_0;
        end else if (de_prev_q && !sobel.de) begin
            case (row_q)
                ROW_0:   row_d = ROW_1;
                default: row_d = ROW_2P;
            endcase
        end
    end

    assign row_eff = sobel.vs ? ROW_0 : row_q;

    // Buffer 1 takes buffer 0's old bit one cycle later, once the registered read returns it.
    edge_line_buf #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb0 (
        .clk       (clk),
        .wr_en_i   (lb0_wr_en),
        .wr_addr_i (col_q),
        .wr_data_i (pix_e),
        .rd_addr_i (col_q),
        .rd_data_o (lb0_rd)
    );

    edge_line_buf #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (s1_wr_en_q),
        .wr_addr_i (s1_addr_q),
        .wr_data_i (lb0_rd),
        .rd_addr_i (col_q),
        .rd_data_o (lb1_rd)
    );

    // Stale buffer contents are masked by the row position of the pixel that read them.
    assign col_taps = {s1_e_q,
                       lb0_rd & (s1_row_q != ROW_0),
                       lb1_rd & (s1_row_q == ROW_2P)};

    always_comb begin
        win_d = '0;
        if (sync_q[0].de) begin
            win_d = {win_q[5:0], col_taps};
        end
    end

    assign win_hit = |win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            col_full_q <= 1'b0;
            de_prev_q  <= 1'b0;
            s1_e_q     <= 1'b0;
            s1_row_q   <= ROW_0;
            s1_wr_en_q <= 1'b0;
            s1_addr_q  <= '0;
            win_q      <= '0;
            sync_q     <= '0;
            data_q     <= 8'h00;
        end else begin
            col_q      <= col_d;
            col_full_q <= col_full_d;
            de_prev_q  <= sobel.de;
            s1_e_q     <= pix_e;
            s1_row_q   <= row_eff;
            s1_wr_en_q <= lb0_wr_en;
            s1_addr_q  <= col_q;
            win_q      <= win_d;
            sync_q     <= {sync_q[SL-1:0], {sobel.vs, sobel.hs, sobel.de}};
            data_q     <= morph_level(sync_q[1].de, win_hit);
        end
    end

    assign morph.vs   = sync_q[SL].vs;
    assign morph.hs   = sync_q[SL].hs;
    assign morph.de   = sync_q[SL].de;
    assign morph.data = data_q;

`ifdef EDGE_STATS_EN
    logic             out_hit_q;
    logic             mvs_prev_q;
    logic             vs_rise;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    assign vs_rise = sync_q[SL].vs & ~mvs_prev_q;

    // A pixel on the frame-boundary cycle belongs to the new frame.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        edge_count_d = edge_count_q;
        if (vs_rise) begin
            edge_count_d = frame_cnt_q;
            frame_cnt_d  = {{(CNT_W-1){1'b0}}, out_hit_q};
        end else if (out_hit_q && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hit_q    <= 1'b0;
            mvs_prev_q   <= 1'b0;
            frame_cnt_q  <= '0;
            edge_count_q <= '0;
        end else begin
            out_hit_q    <= sync_q[1].de & win_hit;
            mvs_prev_q   <= sync_q[SL].vs;
            frame_cnt_q  <= frame_cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`endif

endmodule

// File: tb/tb_edge_dilate_3x3.sv
// Randomised and directed frames for edge_dilate_3x3 checked every cycle against an
// image-level dilation model; define EDGE_STATS_EN to also exercise edge_count.
module tb_edge_dilate_3x3;
    import edge_morph_pkg::*;

    localparam int W    = 8;
    localparam int MAXR = 32;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_dilate_3x3_if sobel();
    edge_dilate_3x3_if morph();
`ifdef EDGE_STATS_EN
    logic [20:0] edge_count;
`endif

    edge_dilate_3x3 #(.IMG_WIDTH(W), .CNT_W(21)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sobel (sobel),
        .morph (morph)
`ifdef EDGE_STATS_EN
        ,
        .edge_count (edge_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] data;
        bit         chk_data;
    } exp_t;

    exp_t pipe[3];
    bit   img[MAXR][MAXC];
    int   mrow, mcol;
    bit   mprev_de;
    int   model_dark;

    bit   dut_img[MAXR][MAXC];
    int   dark_cnt, de_cnt, orow, ocol;
    bit   oprev_de;

    // Model: output = OR over input pixels (r-2..r, c-2..c) of the current frame, 3 cycles later.
    always @(posedge clk) begin : model_cmp
        exp_t n;
        bit   hit;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{vs: 1'b0, hs: 1'b0, de: 1'b0, data: 8'h00, chk_data: 1'b1};
            mrow = 0; mcol = 0; mprev_de = 1'b0;
        end else begin
            n = '{vs: sobel.vs, hs: sobel.hs, de: sobel.de, data: 8'h00, chk_data: 1'b1};
            if (sobel.de) begin
                if (mrow < MAXR && mcol < MAXC) img[mrow][mcol] = ~sobel.data[7];
                if (mcol >= W) begin
                    n.chk_data = 1'b0;
                end else begin
                    hit = 1'b0;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            if (mrow - dr >= 0 && mrow - dr < MAXR && mcol - dc >= 0)
                                hit |= img[mrow - dr][mcol - dc];
                    n.data = hit ? 8'h00 : 8'hFF;
                    if (hit) model_dark++;
                end
                mcol++;
            end else begin
                mcol = 0;
            end
            if (sobel.vs) mrow = 0;
            else if (mprev_de && !sobel.de) mrow++;
            mprev_de = sobel.de;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = n;
        end
        #1;
        chk("syncs", {morph.vs, morph.hs, morph.de}, {pipe[2].vs, pipe[2].hs, pipe[2].de});
        if (pipe[2].chk_data) chk("data", morph.data, pipe[2].data);
        if (!rst_n) begin
            orow = 0; ocol = 0; oprev_de = 1'b0;
        end else begin
            if (morph.de) begin
                if (ocol < W && orow < MAXR) begin
                    de_cnt++;
                    if (morph.data == 8'h00) begin
                        dark_cnt++;
                        dut_img[orow][ocol] = 1'b1;
                    end
                end
                ocol++;
            end else begin
                ocol = 0;
            end
            if (morph.vs) orow = 0;
            else if (oprev_de && !morph.de) orow++;
            oprev_de = morph.de;
        end
    end

    bit stim[MAXR][MAXC];
    int len[MAXR];
    bit rst_req;

    function automatic logic [7:0] pix(input bit is_edge);
        logic [7:0] v;
        v = 8'($urandom);
        v[7] = ~is_edge;
        return v;
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [7:0] d);
        @(negedge clk);
        sobel.vs = vs; sobel.hs = hs; sobel.de = de; sobel.data = d;
    endtask

    task automatic clear_stim();
        for (int r = 0; r < MAXR; r++) begin
            len[r] = W;
            for (int c = 0; c < MAXC; c++) stim[r][c] = 1'b0;
        end
    endtask

    task automatic clear_obs();
        for (int r = 0; r < MAXR; r++)
            for (int c = 0; c < MAXC; c++) dut_img[r][c] = 1'b0;
        dark_cnt = 0; de_cnt = 0; model_dark = 0;
    endtask

    task automatic send_frame(input int nrows);
        repeat (2) drive(1'b1, 1'b0, 1'b0, pix(1'b0));
        repeat (2) drive(1'b0, 1'b0, 1'b0, pix(1'b1));
        for (int r = 0; r < nrows; r++) begin
            drive(1'b0, 1'b1, 1'b0, pix(1'b1));
            repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 1'b0, pix(1'b1));
            for (int c = 0; c < len[r]; c++) begin
                drive(1'b0, 1'b0, 1'b1, pix(stim[r][c]));
                if (rst_req && r == 3 && c == 4) begin
                    @(posedge clk);
                    #2;
                    chk("pre_rst_de", morph.de, 1);
                    rst_n = 1'b0;
                    sobel.de = 1'b0;
                    #1;
                    chk("rst_syncs", {morph.vs, morph.hs, morph.de}, 0);
                    chk("rst_data", morph.data, 0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (4) drive(1'b0, 1'b0, 1'b0, pix(1'b1));
                    return;
                end
            end
            drive(1'b0, 1'b0, 1'b0, pix(1'b1));
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, pix(1'b0));
    endtask

    initial begin
        sobel.vs = 1'b0; sobel.hs = 1'b0; sobel.de = 1'b0; sobel.data = 8'h00;
        rst_req = 1'b0;
        clear_stim();
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_syncs", {morph.vs, morph.hs, morph.de}, 0);
        chk("reset_data", morph.data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all background, 4 lines
        clear_stim(); clear_obs();
        send_frame(4);
        chk("bg_pixels", de_cnt, 32);
        chk("bg_dark", dark_cnt, 0);
        chk("bg_model_dark", model_dark, 0);

        // single edge at row 2 col 3
        clear_stim(); clear_obs();
        stim[2][3] = 1'b1;
        send_frame(6);
        chk("single_dark", dark_cnt, 9);
        chk("single_model_dark", model_dark, 9);
        chk("single_r2c3", dut_img[2][3], 1);
        chk("single_r4c5", dut_img[4][5], 1);
        chk("single_r1c4", dut_img[1][4], 0);
        chk("single_r3c6", dut_img[3][6], 0);
        chk("single_r5c3", dut_img[5][3], 0);

        // edge at top-left corner
        clear_stim(); clear_obs();
        stim[0][0] = 1'b1;
        send_frame(5);
        chk("corner_dark", dark_cnt, 9);
        chk("corner_model_dark", model_dark, 9);
        chk("corner_r0c0", dut_img[0][0], 1);
        chk("corner_r2c2", dut_img[2][2], 1);
        chk("corner_r0c3", dut_img[0][3], 0);
        chk("corner_r3c0", dut_img[3][0], 0);

        // edge at last column must not spill into the next line's start
        clear_stim(); clear_obs();
        stim[1][7] = 1'b1;
        send_frame(5);
        chk("lastcol_dark", dark_cnt, 3);
        chk("lastcol_model_dark", model_dark, 3);
        chk("lastcol_r2c7", dut_img[2][7], 1);
        chk("lastcol_r2c0", dut_img[2][0], 0);
        chk("lastcol_r3c1", dut_img[3][1], 0);

        // over-long line: pixels past the width must not reach the buffers
        clear_stim(); clear_obs();
        len[1] = W + 2;
        stim[1][8] = 1'b1;
        stim[1][9] = 1'b1;
        send_frame(4);
        chk("overlong_dark", dark_cnt, 0);
        chk("overlong_model_dark", model_dark, 0);

        // reset mid row 3 of a dense frame, then a clean single-edge frame
        clear_stim();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < W; c++) stim[r][c] = ($urandom_range(0, 1) == 0);
        rst_req = 1'b1;
        send_frame(6);
        rst_req = 1'b0;
        clear_stim(); clear_obs();
        stim[2][3] = 1'b1;
        send_frame(6);
        chk("post_rst_dark", dark_cnt, 9);
        chk("post_rst_r0c3", dut_img[0][3], 0);
        chk("post_rst_r1c4", dut_img[1][4], 0);

        // random frames
        for (int f = 0; f < 8; f++) begin
            clear_stim();
            for (int r = 0; r < MAXR; r++) begin
                len[r] = ($urandom_range(0, 4) == 0) ? W + 2 : W;
                for (int c = 0; c < MAXC; c++) stim[r][c] = ($urandom_range(0, 5) == 0);
            end
            send_frame($urandom_range(3, 7));
        end

`ifdef EDGE_STATS_EN
        clear_stim();
        stim[2][3] = 1'b1;
        send_frame(6);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h80);
        repeat (6) drive(1'b0, 1'b0, 1'b0, 8'h80);
        chk("stats_isolated", edge_count, 9);
        clear_stim();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++) stim[r][c] = 1'b1;
        send_frame(4);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h80);
        repeat (6) drive(1'b0, 1'b0, 1'b0, 8'h80);
        chk("stats_all_edge", edge_count, 32);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
